// File: rtl/gauss_poly_ctrl.sv
// Sequencer that drives the Gaussian sampler and collects N = 2^LOGN range-checked
// coefficients into RAM. The final coefficient is chosen so that the coefficient sum is odd.
module gauss_poly_ctrl #(
  parameter  int LOGN     = 9,
  parameter  int LIM_BITS = 6,
  parameter  int COEF_W   = 8,
  localparam int VAL_BIT  = (LOGN == 9) ? 7 : 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                gauss_ena,
  input  logic                gauss_val_valid,
  input  logic [VAL_BIT-1:0]  gauss_val,
  output logic                coef_we,
  output logic [LOGN-1:0]     coef_addr,
  output logic [COEF_W-1:0]   coef_data,
  output logic [15:0]         rej_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [LOGN-1:0] LAST_IDX = '1;
  localparam int              LIM      = 1 << (LIM_BITS - 1);

  state_t                     state, state_nx;
  logic   [LOGN-1:0]          idx;
  logic                       parity;
  logic                       take, drop, start_run, in_range;
  logic signed [VAL_BIT-1:0]  s;

  assign s        = gauss_val;
  assign in_range = (int'(s) >= -LIM) && (int'(s) < LIM);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    drop      = 1'b0;
    start_run = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx  = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        // A sample that would leave the coefficient sum even is rejected at the last slot.
        if (gauss_val_valid) begin
          if (!in_range || (idx == LAST_IDX && parity == s[0])) drop = 1'b1;
          else                                                  take = 1'b1;
        end
        if (abort)                          state_nx = S_IDLE;
        else if (take && idx == LAST_IDX)   state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      gauss_ena <= 1'b0;
      done      <= 1'b0;
      coef_we   <= 1'b0;
      coef_addr <= '0;
      coef_data <= '0;
      idx       <= '0;
      parity    <= 1'b0;
      rej_cnt   <= '0;
    end else begin
      // The sampler enable stays high for the whole run so its accumulation is never disturbed.
      busy      <= (state_nx == S_RUN);
      gauss_ena <= (state_nx == S_RUN);
      done      <= (state == S_FIN);
      coef_we   <= take;
      if (take) begin
        coef_addr <= idx;
        coef_data <= COEF_W'(s);
        parity    <= parity ^ s[0];
        if (idx != LAST_IDX) idx <= idx + LOGN'(1);
      end
      if (drop && rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
      if (start_run) begin
        idx     <= '0;
        parity  <= 1'b0;
        rej_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gauss_poly_ctrl.sv
// Randomized bench for gauss_poly_ctrl: a sum-based polynomial model predicts every RAM
// write, the done pulse and the rejection count.
module tb_gauss_poly_ctrl;

  localparam int LOGN    = 9;
  localparam int N       = 1 << LOGN;
  localparam int VAL_BIT = 7;
  localparam int LIM     = 32;

  logic               clk, rst_n, start, abort;
  logic               busy, done, gauss_ena, gauss_val_valid, coef_we;
  logic [VAL_BIT-1:0] gauss_val;
  logic [LOGN-1:0]    coef_addr;
  logic [7:0]         coef_data;
  logic [15:0]        rej_cnt;

  gauss_poly_ctrl #(.LOGN(LOGN), .LIM_BITS(6), .COEF_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .gauss_ena(gauss_ena), .gauss_val_valid(gauss_val_valid), .gauss_val(gauss_val),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .rej_cnt(rej_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a run is a polynomial being filled; the coefficient sum must end odd.
  bit         m_run = 0;
  int         m_acc, m_sum, m_rej;
  int         exp_addr[$];
  logic [7:0] exp_data[$];
  bit         done_pending = 0;
  int         n_writes = 0;
  int         ea;
  logic [7:0] ed;

  task automatic model_step(input int v);
    if (!m_run) return;
    if (v < -LIM || v >= LIM || (m_acc == N - 1 && ((m_sum + v) & 1) == 0)) begin
      if (m_rej < 65535) m_rej++;
    end else begin
      exp_addr.push_back(m_acc);
      exp_data.push_back(8'(v));
      m_sum += v;
      m_acc++;
      if (m_acc == N) m_run = 0;
    end
  endtask

  // Scoreboard: every write must match the model, and done must follow the final write.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (done !== done_pending) begin
        failures++;
        $display("FAIL done_timing actual=%0b expected=%0b t=%0t", done, done_pending, $time);
      end
      done_pending = 0;
      if (coef_we === 1'b1) begin
        n_writes++;
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h t=%0t", coef_addr, coef_data, $time);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          if (coef_addr !== LOGN'(ea) || coef_data !== ed) begin
            failures++;
            $display("FAIL write actual=%0d/%h expected=%0d/%h", coef_addr, coef_data, ea, ed);
          end
          if (ea == N - 1) done_pending = 1;
        end
      end
    end
  end

  task automatic send(input int v);
    gauss_val       = VAL_BIT'(v);
    gauss_val_valid = 1'b1;
    model_step(v);
    @(negedge clk);
    gauss_val_valid = 1'b0;
  endtask

  task automatic rand_val(output int v);
    v = int'($urandom_range(0, 127)) - 64;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_run = 1; m_acc = 0; m_sum = 0; m_rej = 0;
    checks++;
    if (busy !== 1'b1 || gauss_ena !== 1'b1 || rej_cnt !== 16'd0) begin
      failures++;
      $display("FAIL start busy=%0b ena=%0b rej=%0d expected 1/1/0", busy, gauss_ena, rej_cnt);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    m_run = 0;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || gauss_ena !== 1'b0) begin
      failures++;
      $display("FAIL abort busy=%0b ena=%0b expected 0/0", busy, gauss_ena);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout done=%0b expected 1", name, done);
    end
    checks++;
    if (rej_cnt !== 16'(m_rej) || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end rej=%0d busy=%0b expected %0d/0", name, rej_cnt, busy, m_rej);
    end
  endtask

  task automatic run_random(input string name, input bit poke_start);
    int v;
    int guard = 0;
    while (m_run && guard < 20000) begin
      guard++;
      rand_val(v);
      if ($urandom_range(3) == 0) @(negedge clk);
      if (poke_start && $urandom_range(7) == 0) start = 1'b1;
      send(v);
      start = 1'b0;
    end
    wait_done(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, gauss_ena, coef_we} !== 4'b0 || coef_addr !== '0 ||
        coef_data !== 8'h00 || rej_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset busy=%0b done=%0b ena=%0b we=%0b addr=%0d data=%h rej=%0d expected all 0",
               busy, done, gauss_ena, coef_we, coef_addr, coef_data, rej_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_impulse_stream();
    int w0 = n_writes;
    do_start();
    send(1);
    for (int i = 1; i < N; i++) send(0);
    wait_done("impulse");
    checks++;
    if (n_writes - w0 !== N) begin
      failures++;
      $display("FAIL impulse_count actual=%0d expected=%0d", n_writes - w0, N);
    end
  endtask

  task automatic test_range_window();
    do_start();
    for (int i = 0; i < 5; i++) send(0);
    send(32); send(-33); send(31); send(-32);
    repeat (2) @(negedge clk);
    checks++;
    if (rej_cnt !== 16'd2) begin
      failures++;
      $display("FAIL range_rej actual=%0d expected=2", rej_cnt);
    end
    do_abort();
  endtask

  task automatic test_last_parity();
    do_start();
    for (int i = 0; i < N - 1; i++) send(0);
    send(0); send(2); send(3);
    wait_done("parity");
  endtask

  task automatic test_abort_restart();
    int v;
    do_start();
    while (m_acc < 100) begin rand_val(v); send(v); end
    v = int'($urandom_range(0, 63)) - 32;
    gauss_val       = VAL_BIT'(v);
    gauss_val_valid = 1'b1;
    model_step(v);
    do_abort();
    gauss_val_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rej_cnt !== 16'(m_rej) || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold rej=%0d busy=%0b expected %0d/0", rej_cnt, busy, m_rej);
    end
    checks++;
    if (exp_addr.size() != 0) begin
      failures++;
      $display("FAIL abort_pending_write outstanding=%0d expected 0", exp_addr.size());
    end
    do_start();
    send(7);
    do_abort();
  endtask

  task automatic test_ignored_inputs();
    int v;
    for (int i = 0; i < 5; i++) begin rand_val(v); send(v); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gauss_ena !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle busy=%0b ena=%0b expected 0/0", busy, gauss_ena);
    end
    do_start();
    run_random("poke", 1'b1);
  endtask

  task automatic test_async_reset();
    int v;
    do_start();
    for (int i = 0; i < 20; i++) begin rand_val(v); send(v); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, gauss_ena, coef_we} !== 4'b0 || coef_addr !== '0 ||
        coef_data !== 8'h00 || rej_cnt !== 16'd0) begin
      failures++;
      $display("FAIL async_reset busy=%0b ena=%0b we=%0b addr=%0d rej=%0d expected all 0",
               busy, gauss_ena, coef_we, coef_addr, rej_cnt);
    end
    m_run = 0;
    exp_addr.delete();
    exp_data.delete();
    done_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    run_random("post_reset", 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    gauss_val_valid = 1'b0; gauss_val = '0;
    test_reset();
    test_impulse_stream();
    test_range_window();
    test_last_parity();
    test_abort_restart();
    test_ignored_inputs();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
